m68k_bus_sequencer: RTL

//   Sequences one 68000-style bus cycle (S0..S7 plus wait states) per accepted host request.

---
 rtl/m68k_bus_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/m68k_bus_sequencer.sv
// One 68000-style bus cycle (S0..S7 plus wait states) per accepted host request, paced by MCCLK edge strobes.
// Optional bus-error termination is enabled by defining M68K_BERR_EN, which adds the berr_n port.
module m68k_bus_sequencer #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  mcclk_rising,
  input  logic                  mcclk_falling,
  input  logic                  dtack_latch,
`ifdef M68K_BERR_EN
  input  logic                  berr_n,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-2:0] bus_addr,
  output logic                  bus_as_n,
  output logic                  bus_uds_n,
  output logic                  bus_lds_n,
  output logic                  bus_rw,
  output logic [15:0]           bus_dout,
  output logic                  bus_doe,
  input  logic [15:0]           bus_din
);

  typedef enum logic [3:0] {
    IDLE, ARM, S0, S1, S2, S3, S4, S5, S6, S7
  } state_t;

  state_t                state_reg, state_next;
  logic                  rw_reg, rw_next;
  logic                  byte_reg, byte_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [15:0]           wdata_reg, wdata_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic                  resp_err_reg, resp_err_next;
  logic [15:0]           rdata_reg, rdata_next;
  logic [ADDR_WIDTH-2:0] bus_addr_reg, bus_addr_next;
  logic                  as_n_reg, as_n_next;
  logic                  uds_n_reg, uds_n_next;
  logic                  lds_n_reg, lds_n_next;
  logic                  bus_rw_reg, bus_rw_next;
  logic [15:0]           dout_reg, dout_next;
  logic                  doe_reg, doe_next;

  // Coincident strobes are treated as no edge at all.
  logic rise, fall, berr_hit;
  assign rise = mcclk_rising & ~mcclk_falling;
  assign fall = mcclk_falling & ~mcclk_rising;

`ifdef M68K_BERR_EN
  assign berr_hit = ~berr_n;
`else
  assign berr_hit = 1'b0;
`endif

  // Word transfers use both lanes; byte A0=0 is the upper (UDS) lane.
  logic        uds_sel, lds_sel;
  logic [15:0] lane_data;
  assign uds_sel   = ~byte_reg | ~addr_reg[0];
  assign lds_sel   = ~byte_reg |  addr_reg[0];
  assign lane_data = !byte_reg   ? bus_din :
                     addr_reg[0] ? {8'h00, bus_din[7:0]} : {8'h00, bus_din[15:8]};

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rw_reg         <= 1'b1;
      byte_reg       <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      rdata_reg      <= '0;
      bus_addr_reg   <= '0;
      as_n_reg       <= 1'b1;
      uds_n_reg      <= 1'b1;
      lds_n_reg      <= 1'b1;
      bus_rw_reg     <= 1'b1;
      dout_reg       <= '0;
      doe_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rw_reg         <= rw_next;
      byte_reg       <= byte_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      rdata_reg      <= rdata_next;
      bus_addr_reg   <= bus_addr_next;
      as_n_reg       <= as_n_next;
      uds_n_reg      <= uds_n_next;
      lds_n_reg      <= lds_n_next;
      bus_rw_reg     <= bus_rw_next;
      dout_reg       <= dout_next;
      doe_reg        <= doe_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rw_next         = rw_reg;
    byte_next       = byte_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    rdata_next      = rdata_reg;
    bus_addr_next   = bus_addr_reg;
    as_n_next       = as_n_reg;
    uds_n_next      = uds_n_reg;
    lds_n_next      = lds_n_reg;
    bus_rw_next     = bus_rw_reg;
    dout_next       = dout_reg;
    doe_next        = doe_reg;
    case (state_reg)
      IDLE: if (req_valid) begin
        rw_next    = req_rw;
        byte_next  = req_byte;
        addr_next  = req_addr;
        wdata_next = req_wdata;
        state_next = ARM;
      end
      ARM: if (rise) state_next = S0;
      S0: if (fall) begin
        state_next    = S1;
        bus_addr_next = addr_reg[ADDR_WIDTH-1:1];
        bus_rw_next   = rw_reg;
      end
      S1: if (rise) begin
        state_next = S2;
        as_n_next  = 1'b0;
        if (rw_reg) begin
          uds_n_next = ~uds_sel;
          lds_n_next = ~lds_sel;
        end
      end
      S2: if (fall) begin
        state_next = S3;
        if (!rw_reg) begin
          doe_next  = 1'b1;
          dout_next = byte_reg ? {wdata_reg[7:0], wdata_reg[7:0]} : wdata_reg;
        end
      end
      S3: if (rise) begin
        state_next = S4;
        if (!rw_reg) begin
          uds_n_next = ~uds_sel;
          lds_n_next = ~lds_sel;
        end
      end
      // Wait states: one per MCCLK period until DTACK (or bus error) is seen.
      S4: if (fall) begin
        if (berr_hit) begin
          state_next      = S7;
          as_n_next       = 1'b1;
          uds_n_next      = 1'b1;
          lds_n_next      = 1'b1;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
        end else if (dtack_latch) begin
          state_next = S5;
        end
      end
      S5: if (rise) state_next = S6;
      S6: if (fall) begin
        state_next      = S7;
        if (rw_reg) rdata_next = lane_data;
        as_n_next       = 1'b1;
        uds_n_next      = 1'b1;
        lds_n_next      = 1'b1;
        resp_valid_next = 1'b1;
      end
      S7: if (rise) begin
        state_next  = IDLE;
        doe_next    = 1'b0;
        bus_rw_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = rdata_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_as_n   = as_n_reg;
  assign bus_uds_n  = uds_n_reg;
  assign bus_lds_n  = lds_n_reg;
  assign bus_rw     = bus_rw_reg;
  assign bus_dout   = dout_reg;
  assign bus_doe    = doe_reg;

endmodule
